// File: rtl/calc_pkg.sv
// Shared op-codes, FSM states and default widths for the calculator arithmetic stage.
package calc_pkg;

  localparam int OPD_W_DEF = 10;
  localparam int RES_W_DEF = 20;
  localparam int OP_W_DEF  = 3;

  localparam logic [OP_W_DEF-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W_DEF-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W_DEF-1:0] OP_MUL  = 3'b010;
  localparam logic [OP_W_DEF-1:0] OP_DIV  = 3'b011;
  localparam logic [OP_W_DEF-1:0] OP_CLR  = 3'b100;
  localparam logic [OP_W_DEF-1:0] OP_EQU  = 3'b101;
  localparam logic [OP_W_DEF-1:0] OP_NONE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HAVE_OP,
    ST_MUL,
    ST_DIV,
    ST_SHOW,
    ST_ERR
  } calc_state_e;

  function automatic logic is_arith(input logic [OP_W_DEF-1:0] code);
    return code[OP_W_DEF-1] == 1'b0;
  endfunction

endpackage

// File: rtl/calc_iter_muldiv.sv
// Iterative unsigned multiply (shift-add, one multiplier bit per cycle) and
// restoring divide (one quotient bit per cycle) sharing one shift register and counter.
module calc_iter_muldiv
  import calc_pkg::*;
#(
  parameter int OPD_W = OPD_W_DEF,
  parameter int RES_W = RES_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             is_div_i,
  input  logic [RES_W-1:0] a_i,
  input  logic [OPD_W-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [RES_W-1:0] result_o,
  output logic             ovf_o
);

  localparam int SH_W  = RES_W + OPD_W + 1;
  localparam int CNT_W = $clog2(RES_W + 1);

  logic [SH_W-1:0]  sh_q, sh_d;
  logic [RES_W-1:0] ma_q, ma_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, div_q, div_d;

  logic [RES_W:0]   mul_sum;
  logic [OPD_W:0]   div_shf, div_trl;
  logic             div_ge;

  // Multiply: sh = {partial product, remaining multiplier}; divide: sh = {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = sh_q[SH_W-1:OPD_W] + (sh_q[0] ? {1'b0, ma_q} : '0);
    div_shf = {sh_q[SH_W-2:RES_W], sh_q[RES_W-1]};
    div_trl = div_shf - {1'b0, ma_q[OPD_W-1:0]};
    div_ge  = (div_shf >= {1'b0, ma_q[OPD_W-1:0]});
  end

  always_comb begin
    sh_d   = sh_q;
    ma_d   = ma_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    div_d  = div_q;
    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      div_d  = is_div_i;
      cnt_d  = is_div_i ? CNT_W'(RES_W) : CNT_W'(OPD_W);
      ma_d   = is_div_i ? {{(RES_W-OPD_W){1'b0}}, b_i} : a_i;
      sh_d   = is_div_i ? {{(OPD_W+1){1'b0}}, a_i} : {{(RES_W+1){1'b0}}, b_i};
    end else if (busy_q) begin
      sh_d  = div_q ? {(div_ge ? div_trl : div_shf), sh_q[RES_W-2:0], div_ge}
                    : {1'b0, mul_sum, sh_q[OPD_W-1:1]};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      ma_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      ma_q   <= ma_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      div_q  <= div_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = sh_q[RES_W-1:0];
  assign ovf_o    = !div_q && (|sh_q[RES_W+OPD_W-1:RES_W]);

endmodule

// File: rtl/calc_engine.sv
// Calculator arithmetic stage: accumulator FSM with chained equals and display muxing.
// Define CALC_SIGNED_EN for two's-complement operands and accumulator.
//
//  state   | meaning
//  IDLE    | no pending operator
//  HAVE_OP | lhs and operator captured, waiting for equal
//  MUL     | iterative multiply running
//  DIV     | iterative divide running
//  SHOW    | result in acc is displayed; equal repeats the last op
//  ERR     | divide by zero, only clear leaves
module calc_engine
  import calc_pkg::*;
#(
  parameter int OPD_W = OPD_W_DEF,
  parameter int RES_W = RES_W_DEF,
  parameter int OP_W  = OP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [OP_W-1:0]  op_code,
  input  logic [OPD_W-1:0] operand,
  output logic             busy,
  output logic             clr_entry,
  output logic [RES_W-1:0] disp_value,
  output logic [OP_W-1:0]  disp_sign,
  output logic             show_result,
  output logic             err
);

  calc_state_e      state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d, lhs_q, lhs_d;
  logic [OP_W-1:0]  pend_q, pend_d, sign_q, sign_d;
  logic             show_q, show_d, err_q, err_d, clr_q, clr_d;

  logic             do_clr, do_equ, arith, locked, accept, div_zero;
  logic [RES_W-1:0] opa, opb, as_res, md_a, md_res, fix_res;
  logic [OPD_W-1:0] md_b;
  logic             as_ovf, md_ovf, fix_ovf, md_start, md_div, md_busy, md_done;

  assign do_clr   = op_valid && (op_code == OP_CLR);
  assign do_equ   = op_valid && (op_code == OP_EQU);
  assign arith    = op_valid && is_arith(op_code);
  assign locked   = state_q inside {ST_MUL, ST_DIV, ST_ERR};
  assign accept   = do_clr || (op_valid && !locked);
  assign div_zero = (operand == '0);
  assign opa      = (state_q == ST_SHOW) ? acc_q : lhs_q;

  assign md_div   = (pend_q == OP_DIV);
  assign md_start = do_equ && (state_q inside {ST_HAVE_OP, ST_SHOW}) &&
                    ((pend_q == OP_MUL) || (md_div && !div_zero));

`ifdef CALC_SIGNED_EN
  localparam logic [RES_W-1:0] MOST_NEG = {1'b1, {(RES_W-1){1'b0}}};
  logic             neg_q;
  logic [RES_W-1:0] sum_s, dif_s;

  // The iterative unit sees magnitudes; the sign is restored when it finishes.
  always_comb begin
    opb     = {{(RES_W-OPD_W){operand[OPD_W-1]}}, operand};
    sum_s   = opa + opb;
    dif_s   = opa - opb;
    as_res  = (pend_q == OP_SUB) ? dif_s : sum_s;
    as_ovf  = (pend_q == OP_SUB)
              ? ((opa[RES_W-1] != opb[RES_W-1]) && (dif_s[RES_W-1] != opa[RES_W-1]))
              : ((opa[RES_W-1] == opb[RES_W-1]) && (sum_s[RES_W-1] != opa[RES_W-1]));
    md_a    = opa[RES_W-1] ? -opa : opa;
    md_b    = operand[OPD_W-1] ? -operand : operand;
    fix_res = neg_q ? -md_res : md_res;
    fix_ovf = md_ovf || (neg_q ? (md_res > MOST_NEG) : md_res[RES_W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        neg_q <= 1'b0;
    else if (md_start) neg_q <= opa[RES_W-1] ^ operand[OPD_W-1];
  end
`else
  logic [RES_W:0] sum_u, dif_u;

  always_comb begin
    opb     = {{(RES_W-OPD_W){1'b0}}, operand};
    sum_u   = {1'b0, opa} + {1'b0, opb};
    dif_u   = {1'b0, opa} - {1'b0, opb};
    as_res  = (pend_q == OP_SUB) ? dif_u[RES_W-1:0] : sum_u[RES_W-1:0];
    as_ovf  = (pend_q == OP_SUB) ? dif_u[RES_W] : sum_u[RES_W];
    md_a    = opa;
    md_b    = operand;
    fix_res = md_res;
    fix_ovf = md_ovf;
  end
`endif

  calc_iter_muldiv #(.OPD_W(OPD_W), .RES_W(RES_W)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_start),
    .abort_i  (do_clr),
    .is_div_i (md_div),
    .a_i      (md_a),
    .b_i      (md_b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res),
    .ovf_o    (md_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arith) state_d = ST_HAVE_OP;
      ST_HAVE_OP, ST_SHOW: begin
        if (arith) begin
          state_d = ST_HAVE_OP;
        end else if (do_equ) begin
          case (pend_q)
            OP_MUL:  state_d = ST_MUL;
            OP_DIV:  state_d = div_zero ? ST_ERR : ST_DIV;
            default: state_d = ST_SHOW;
          endcase
        end
      end
      ST_MUL, ST_DIV: if (md_done) state_d = ST_SHOW;
      ST_ERR: state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
    // Clear beats everything, including a completion in the same cycle.
    if (do_clr) state_d = ST_IDLE;
  end

  always_comb begin
    acc_d  = acc_q;
    lhs_d  = lhs_q;
    pend_d = pend_q;
    show_d = show_q;
    err_d  = err_q;
    clr_d  = 1'b0;
    sign_d = accept ? op_code : sign_q;
    if (do_clr) begin
      acc_d  = '0;
      lhs_d  = '0;
      pend_d = OP_ADD;
      show_d = 1'b0;
      err_d  = 1'b0;
      clr_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (arith) begin
          lhs_d  = opb;
          pend_d = op_code;
          clr_d  = 1'b1;
        end
        ST_HAVE_OP, ST_SHOW: begin
          if (arith) begin
            pend_d = op_code;
            if (state_q == ST_SHOW) begin
              lhs_d  = acc_q;
              show_d = 1'b0;
              clr_d  = 1'b1;
            end
          end else if (do_equ) begin
            if (pend_q == OP_ADD || pend_q == OP_SUB) begin
              acc_d  = as_res;
              show_d = 1'b1;
              err_d  = err_q | as_ovf;
            end else if (md_div && div_zero) begin
              acc_d  = '1;
              show_d = 1'b1;
              err_d  = 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: if (md_done) begin
          acc_d  = fix_res;
          show_d = 1'b1;
          err_d  = err_q | fix_ovf;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      lhs_q  <= '0;
      pend_q <= OP_ADD;
      sign_q <= OP_NONE;
      show_q <= 1'b0;
      err_q  <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      lhs_q  <= lhs_d;
      pend_q <= pend_d;
      sign_q <= sign_d;
      show_q <= show_d;
      err_q  <= err_d;
      clr_q  <= clr_d;
    end
  end

  assign busy        = md_busy;
  assign clr_entry   = clr_q;
  assign disp_value  = show_q ? acc_q : {{(RES_W-OPD_W){1'b0}}, operand};
  assign disp_sign   = sign_q;
  assign show_result = show_q;
  assign err         = err_q;

endmodule

// File: tb/tb_calc_engine.sv
// Scoreboard bench for calc_engine: expected results queued at the equal strobe,
// checked when the result lands (after busy for multiply/divide).
module tb_calc_engine;
  import calc_pkg::*;

  localparam int OPD_W = 10;
  localparam int RES_W = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             op_valid = 1'b0;
  logic [2:0]       op_code = OP_NONE;
  logic [OPD_W-1:0] operand = '0;
  logic             busy, clr_entry, show_result, err;
  logic [RES_W-1:0] disp_value;
  logic [2:0]       disp_sign;

  calc_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .operand     (operand),
    .busy        (busy),
    .clr_entry   (clr_entry),
    .disp_value  (disp_value),
    .disp_sign   (disp_sign),
    .show_result (show_result),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RES_W-1:0] val;
    logic             err;
    int               busy_cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   clr_cnt = 0;

  always @(negedge clk) if (clr_entry) clr_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [2:0] c, input logic [OPD_W-1:0] v);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = c;
    operand  = v;
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = OP_NONE;
  endtask

  task automatic sb_push(input logic [RES_W-1:0] v, input logic e, input int b);
    exp_t x;
    x.val = v;
    x.err = e;
    x.busy_cyc = b;
    sb.push_back(x);
  endtask

  task automatic sb_check(input string tag);
    int   n;
    exp_t x;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_timeout"}, 32'(n < 200), 1);
    if (n > 0) @(negedge clk);
    chk({tag, "_sb"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({tag, "_busy"}, n, x.busy_cyc);
      chk({tag, "_val"}, disp_value, x.val);
      chk({tag, "_err"}, err, x.err);
      chk({tag, "_show"}, show_result, 1);
    end
  endtask

  task automatic do_clear(input string tag);
    strobe(OP_CLR, 10'd0);
    chk({tag, "_clr_err"}, err, 0);
    chk({tag, "_clr_show"}, show_result, 0);
    chk({tag, "_clr_busy"}, busy, 0);
  endtask

  initial begin
    int c0;
`ifdef CALC_SIGNED_EN
    localparam logic ERR_SUB = 1'b0;
`else
    localparam logic ERR_SUB = 1'b1;
`endif
    operand = 10'd5;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_clr", clr_entry, 0);
    chk("rst_sign", disp_sign, 3'b111);
    chk("rst_show", show_result, 0);
    chk("rst_err", err, 0);
    chk("rst_disp", disp_value, 5);

    // add then equal
    c0 = clr_cnt;
    strobe(OP_ADD, 10'd12);
    chk("add_sign", disp_sign, OP_ADD);
    chk("add_clr", clr_entry, 1);
    sb_push(20'd42, 1'b0, 0);
    strobe(OP_EQU, 10'd30);
    sb_check("add");
    chk("add_clr_once", clr_cnt - c0, 1);
    chk("equ_sign", disp_sign, OP_EQU);

    // multiply, full-width operands
    do_clear("t2");
    strobe(OP_MUL, 10'd1023);
`ifdef CALC_SIGNED_EN
    sb_push(20'd1, 1'b0, 10);
`else
    sb_push(20'd1046529, 1'b0, 10);
`endif
    strobe(OP_EQU, 10'd1023);
    sb_check("mul");
`ifndef CALC_SIGNED_EN
    // product past RES_W truncates and flags
    strobe(OP_MUL, 10'd0);
    sb_push(20'd1044482, 1'b1, 10);
    strobe(OP_EQU, 10'd2);
    sb_check("mul_ovf");
`endif

    // divide then chained equal
    do_clear("t3");
    strobe(OP_DIV, 10'd100);
    sb_push(20'd14, 1'b0, 20);
    strobe(OP_EQU, 10'd7);
    sb_check("div");
    sb_push(20'd7, 1'b0, 20);
    strobe(OP_EQU, 10'd2);
    sb_check("div_chain");

    // subtract with borrow
    do_clear("t4");
    strobe(OP_SUB, 10'd5);
    sb_push(20'hFFFFC, ERR_SUB, 0);
    strobe(OP_EQU, 10'd9);
    sb_check("sub");
    strobe(OP_CLR, 10'd77);
    chk("sub_clr_disp", disp_value, 77);
    chk("sub_clr_err", err, 0);
    chk("sub_clr_show", show_result, 0);

    // divide by zero, ERR locks out everything but clear
    strobe(OP_DIV, 10'd50);
    sb_push(20'hFFFFF, 1'b1, 0);
    strobe(OP_EQU, 10'd0);
    sb_check("div0");
    strobe(OP_ADD, 10'd3);
    chk("err_add_disp", disp_value, 20'hFFFFF);
    chk("err_add_sign", disp_sign, OP_EQU);
    chk("err_add_clr", clr_entry, 0);
    chk("err_add_err", err, 1);
    do_clear("t5");
    chk("t5_sign", disp_sign, OP_CLR);

    // clear aborts a running multiply
    strobe(OP_MUL, 10'd700);
    strobe(OP_EQU, 10'd900);
    chk("abort_busy_on", busy, 1);
    repeat (3) @(negedge clk);
    strobe(OP_CLR, 10'd9);
    chk("abort_busy_off", busy, 0);
    repeat (15) @(negedge clk);
    chk("abort_busy_stay", busy, 0);
    chk("abort_show", show_result, 0);
    chk("abort_disp", disp_value, 9);
    chk("abort_err", err, 0);

    // chained add after abort
    strobe(OP_ADD, 10'd10);
    sb_push(20'd15, 1'b0, 0);
    strobe(OP_EQU, 10'd5);
    sb_check("add_c1");
    sb_push(20'd20, 1'b0, 0);
    strobe(OP_EQU, 10'd5);
    sb_check("add_c2");

`ifdef CALC_SIGNED_EN
    do_clear("s1");
    strobe(OP_SUB, 10'd3);
    sb_push(20'hFFFFE, 1'b0, 0);
    strobe(OP_EQU, 10'd5);
    sb_check("s_sub");
    do_clear("s2");
    strobe(OP_MUL, 10'd3);
    sb_push(20'hFFFF4, 1'b0, 10);
    strobe(OP_EQU, 10'd1020);
    sb_check("s_mul");
    strobe(OP_DIV, 10'd0);
    sb_push(20'hFFFFE, 1'b0, 20);
    strobe(OP_EQU, 10'd5);
    sb_check("s_div");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/calc_engine.md
Name: calc_engine

Overview:
- Parametrised, clocked successor to the keypad calculator's arithmetic stage.
- Accepts operator events and entry values from the key decoder and number-entry register.
- Holds an accumulator and performs add, subtract, multiply and divide with chained-equals semantics.
- Feeds the display driver with the value and sign to show, plus an error indication.
- Multiply and divide are iterative multi-cycle units with a busy handshake, so wide operands fit small FPGAs.

Parameters:
- OPD_W, 10, entry operand width in bits.
- RES_W, 20, accumulator/result width; must be >= 2*OPD_W.
- OP_W, 3, operator code width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  single-cycle strobe: op_code/operand are valid this cycle.
- op_code  in  OP_W  operator code: 000 add, 001 sub, 010 mul, 011 div, 100 clear, 101 equal, 111 none.
- operand  in  OPD_W  current entry value.
- busy  out  1  high while an iterative operation runs.
- clr_entry  out  1  one-cycle pulse asking the entry register to reset.
- disp_value  out  RES_W  value to display.
- disp_sign  out  OP_W  last accepted op_code, for the sign indicator.
- show_result  out  1  1 = disp_value is the accumulator; 0 = zero-extended operand.
- err  out  1  sticky error flag (divide-by-zero, overflow, borrow).

Behaviour:
- Reset values: busy=0, clr_entry=0, disp_sign=3'b111, show_result=0, err=0. Internal state: acc=0, lhs=0, pend_op=add, state=IDLE.
- disp_value = show_result ? acc : {0, operand}. It is combinational from registers/inputs.
- FSM states: IDLE, HAVE_OP, MUL, DIV, SHOW, ERR.
- IDLE:
  - arithmetic op_valid → lhs<=operand, pend_op<=op_code, clr_entry pulse, go to HAVE_OP.
  - equal → no change.
- HAVE_OP:
  - arithmetic op → pend_op updated only; lhs unchanged; no clr_entry.
  - equal → start pend_op with (lhs, operand).
- SHOW (result displayed):
  - equal → repeat pend_op with (acc, operand), i.e. chained equals.
  - arithmetic op → lhs<=acc[...], pend_op<=op_code, show_result<=0, clr_entry, go to HAVE_OP.
- Add/sub complete in the cycle after the strobe. acc gets the RES_W result, show_result<=1, go to SHOW.
  - Sub borrow: result wraps mod 2^RES_W and err<=1.
  - Add carry out of RES_W: result wraps and err<=1.
- MUL: shift-add, one operand bit per cycle, exactly OPD_W cycles; busy high throughout. Any product bit above RES_W sets err; the result is truncated.
- DIV: restoring, one quotient bit per cycle, exactly RES_W cycles. operand==0 is detected at start: no iteration, acc<=all ones, err<=1, go to ERR.
- op_valid while busy: ignored, except clear. disp_sign is not updated.
- Clear, any state, including mid-MUL/DIV:
  - abort the operation; acc<=0; err<=0; show_result<=0; busy<=0; clr_entry pulse; go to IDLE next cycle.
- ERR: display all ones with show_result=1. Only clear is accepted.
- disp_sign<=op_code on every accepted op_valid, including none (111).
- Simultaneous completion of MUL/DIV and an arriving clear: clear wins.

Optional Feature:
- CALC_SIGNED_EN defined:
  - operand and acc are two's complement.
  - Sub never flags borrow; overflow uses signed rules.
  - MUL/DIV operate on magnitudes and fix the sign at completion (quotient truncates toward zero).
  - Most-negative / -1 sets err.
- Not defined: all arithmetic unsigned as above.

Decomposition:
- Shared package calc_pkg:
  - op-code localparams (OP_ADD..OP_NONE);
  - FSM state enum;
  - default width constants.
- One natural sub-module, calc_iter_muldiv: iterative multiply/divide datapath with start/done/busy and a shared shift register and counter. calc_engine holds the FSM, accumulator and display muxing.

Test Plan:
- Default parameters: op add operand 12, then equal operand 30 → SHOW, disp_value=42, show_result=1, err=0. clr_entry pulsed exactly once, after the add.
- mul 1023, then equal 1023 → busy high exactly 10 cycles, then disp_value=1046529, err=0.
- div 100, equal 7 → busy 20 cycles, disp_value=14. A second equal with operand 2 → disp_value=7 (chained).
- sub 5, equal 9 → disp_value=2^20-4, err=1. Then clear → disp_value=operand, err=0, state IDLE.
- div 50, equal 0 → disp_value=all ones, err=1. A following add strobe is ignored; clear recovers.
- mul 700, equal 900; at cycle 4 of busy apply clear → busy falls next cycle, acc=0, no result is written. With CALC_SIGNED_EN: sub 3, equal 5 → disp_value=-2, err=0.
